// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite register-file slice.
// The write-side block and any later read-side block both use these.
package axil_pkg;

   // AXI-Lite response codes driven on BRESP (and later RRESP)
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_e;

   // Write transaction sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      COMMIT = 2'b01,
      RESP   = 2'b10
   } axil_state_e;

endpackage

// File: rtl/axil_addr_decode.sv
// Maps a byte address onto a word-register index inside the register window.
// Byte-lane bits are ignored. Addresses below the base are rejected, and so
// are addresses past the last register.
module axil_addr_decode #(
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        NUM_REGS       = 16,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000
) (
   input  logic [AXI_ADDR_WIDTH-1:0]   addr,
   output logic [$clog2(NUM_REGS)-1:0] index,
   output logic                        hit
);

   localparam int IDX_W = $clog2(NUM_REGS);

   logic [AXI_ADDR_WIDTH-1:0] offset;
   logic [AXI_ADDR_WIDTH-1:0] upper;

   // Offset wraps modulo the address width, so the lower-bound test is kept
   // separate. Every offset bit above the index field must be zero.
   always_comb begin
      offset = addr - BASE_ADDR;
      upper  = offset >> (IDX_W + 2);
      index  = offset[IDX_W+1:2];
      hit    = (addr >= BASE_ADDR) && (upper == '0);
   end

endmodule

// File: rtl/axil_wr_regfile.sv
// AXI-Lite write-only register file.
// AW and W are captured independently. The write is committed one cycle after
// both have been captured, and the B response follows in the next cycle.
// Only one transaction is in flight at a time.
module axil_wr_regfile
   import axil_pkg::*;
#(
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        NUM_REGS       = 16,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
   input  logic                          s_axil_awvalid,
   output logic                          s_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
   input  logic                          s_axil_wvalid,
   output logic                          s_axil_wready,
   output logic [1:0]                    s_axil_bresp,
   output logic                          s_axil_bvalid,
   input  logic                          s_axil_bready,
   output logic [AXI_DATA_WIDTH-1:0]     reg_q [NUM_REGS],
   output logic [NUM_REGS-1:0]           reg_wr_pulse
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NUM_REGS);

   axil_state_e               state_q, state_d;
   logic                      aw_cap_q, aw_cap_d;
   logic                      w_cap_q, w_cap_d;
   logic                      awready_q, awready_d;
   logic                      wready_q, wready_d;
   logic                      bvalid_q;
   axil_resp_e                bresp_q;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]         wstrb_q;
   logic [IDX_W-1:0]          dec_index;
   logic                      dec_hit;
   logic                      aw_hs, w_hs, b_hs;

   // Replace only the byte lanes whose strobe is set
   function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
      input logic [AXI_DATA_WIDTH-1:0] cur,
      input logic [AXI_DATA_WIDTH-1:0] wd,
      input logic [STRB_W-1:0]         strb
   );
      logic [AXI_DATA_WIDTH-1:0] res;
      res = cur;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

   axil_addr_decode #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
      .NUM_REGS       (NUM_REGS),
      .BASE_ADDR      (BASE_ADDR)
   ) u_decode (
      .addr  (awaddr_q),
      .index (dec_index),
      .hit   (dec_hit)
   );

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;

   assign aw_hs = s_axil_awvalid & awready_q;
   assign w_hs  = s_axil_wvalid & wready_q;
   assign b_hs  = bvalid_q & s_axil_bready;

   // State and control registers
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         aw_cap_q  <= 1'b0;
         w_cap_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_cap_q  <= aw_cap_d;
         w_cap_q   <= w_cap_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
      end
   end

   // Next state. The capture flags stay set until the response handshake,
   // which blocks a second AW or W for the same transaction.
   always_comb begin
      aw_cap_d = aw_cap_q | aw_hs;
      w_cap_d  = w_cap_q | w_hs;
      state_d  = state_q;
      case (state_q)
         IDLE:    if (aw_cap_d && w_cap_d) state_d = COMMIT;
         COMMIT:  state_d = RESP;
         RESP:    if (b_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (b_hs) begin
         aw_cap_d = 1'b0;
         w_cap_d  = 1'b0;
      end
   end

   // Ready outputs for the next cycle. They are computed from the next state
   // so that the registered readies drop on the same edge that captures.
   always_comb begin
      awready_d = (state_d == IDLE) && !aw_cap_d;
      wready_d  = (state_d == IDLE) && !w_cap_d;
   end

   // Response channel and per-register write strobe; both are set on the commit edge
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         bvalid_q     <= 1'b0;
         bresp_q      <= OKAY;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (state_q == COMMIT) begin
            bvalid_q <= 1'b1;
            bresp_q  <= dec_hit ? OKAY : SLVERR;
            if (dec_hit) reg_wr_pulse[dec_index] <= 1'b1;
         end else if (b_hs) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // Hold the captured address and data beats for the commit cycle
   always_ff @(posedge aclk) begin
      if (aw_hs) awaddr_q <= s_axil_awaddr;
      if (w_hs) begin
         wdata_q <= s_axil_wdata;
         wstrb_q <= s_axil_wstrb;
      end
   end

   // Register array. A strobe of zero still counts as a write and leaves the data unchanged.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
      end else if ((state_q == COMMIT) && dec_hit) begin
         reg_q[dec_index] <= merge_bytes(reg_q[dec_index], wdata_q, wstrb_q);
      end
   end

endmodule

// File: tb/tb_axil_wr_regfile.sv
// Bench for axil_wr_regfile: directed scenarios plus random transactions,
// checked every cycle against a transaction-level model of the register file.
module tb_axil_wr_regfile;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          NREG = 16;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_axil_awaddr = '0;
   logic        s_axil_awvalid = 1'b0;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata = '0;
   logic [3:0]  s_axil_wstrb = '0;
   logic        s_axil_wvalid = 1'b0;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready = 1'b0;
   logic [31:0] reg_q [NREG];
   logic [15:0] reg_wr_pulse;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   axil_wr_regfile dut (
      .aclk           (clk),
      .aresetn        (aresetn),
      .s_axil_awaddr  (s_axil_awaddr),
      .s_axil_awvalid (s_axil_awvalid),
      .s_axil_awready (s_axil_awready),
      .s_axil_wdata   (s_axil_wdata),
      .s_axil_wstrb   (s_axil_wstrb),
      .s_axil_wvalid  (s_axil_wvalid),
      .s_axil_wready  (s_axil_wready),
      .s_axil_bresp   (s_axil_bresp),
      .s_axil_bvalid  (s_axil_bvalid),
      .s_axil_bready  (s_axil_bready),
      .reg_q          (reg_q),
      .reg_wr_pulse   (reg_wr_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_phase = 0;          // 0 accepting, 1 write pending, 2 response pending
   bit          m_have_aw = 0, m_have_w = 0;
   logic [31:0] m_addr = '0, m_data = '0;
   logic [3:0]  m_strb = '0;
   bit          m_awready = 0, m_wready = 0, m_bvalid = 0;
   logic [1:0]  m_bresp = 2'b00;
   logic [15:0] m_pulse = '0;
   logic [31:0] m_regs [NREG];

   function automatic bit in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && ((off / 4) < NREG);
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 4; i++) if (s[i]) mask[8*i +: 8] = 8'hFF;
      return (old & ~mask) | (d & mask);
   endfunction

   always @(posedge clk) begin
      bit hs_aw, hs_w, hs_b;
      int idx;
      if (!aresetn) begin
         m_phase = 0; m_have_aw = 0; m_have_w = 0;
         m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00; m_pulse = '0;
         for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      end else begin
         hs_aw = s_axil_awvalid && m_awready;
         hs_w  = s_axil_wvalid && m_wready;
         hs_b  = m_bvalid && s_axil_bready;
         m_pulse = '0;
         if (m_phase == 0) begin
            if (hs_aw) begin m_have_aw = 1; m_addr = s_axil_awaddr; end
            if (hs_w)  begin m_have_w = 1; m_data = s_axil_wdata; m_strb = s_axil_wstrb; end
            if (m_have_aw && m_have_w) m_phase = 1;
         end else if (m_phase == 1) begin
            if (in_range(m_addr)) begin
               idx = int'((m_addr - BASE) / 4);
               m_regs[idx] = apply_strb(m_regs[idx], m_data, m_strb);
               m_pulse[idx] = 1'b1;
               m_bresp = 2'b00;
            end else begin
               m_bresp = 2'b10;
            end
            m_bvalid = 1;
            m_phase = 2;
         end else if (hs_b) begin
            m_bvalid = 0; m_have_aw = 0; m_have_w = 0; m_phase = 0;
         end
         m_awready = (m_phase == 0) && !m_have_aw;
         m_wready  = (m_phase == 0) && !m_have_w;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("awready", 32'(s_axil_awready), 32'(m_awready));
         chk("wready", 32'(s_axil_wready), 32'(m_wready));
         chk("bvalid", 32'(s_axil_bvalid), 32'(m_bvalid));
         if (m_bvalid) chk("bresp", 32'(s_axil_bresp), 32'(m_bresp));
         chk("reg_wr_pulse", 32'(reg_wr_pulse), 32'(m_pulse));
         for (int i = 0; i < NREG; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i], m_regs[i]);
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_aw(input logic [31:0] addr, input int dly);
      int k;
      repeat (dly) @(negedge clk);
      s_axil_awaddr  = addr;
      s_axil_awvalid = 1'b1;
      k = 0;
      while (!s_axil_awready && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) chk("aw_wait", 32'(s_axil_awready), 32'd1);
      @(negedge clk);
      s_axil_awvalid = 1'b0;
   endtask

   task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
      int k;
      repeat (dly) @(negedge clk);
      s_axil_wdata  = data;
      s_axil_wstrb  = strb;
      s_axil_wvalid = 1'b1;
      k = 0;
      while (!s_axil_wready && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) chk("w_wait", 32'(s_axil_wready), 32'd1);
      @(negedge clk);
      s_axil_wvalid = 1'b0;
   endtask

   task automatic drive_b(input int stall, output logic [1:0] resp);
      int k;
      s_axil_bready = 1'b0;
      k = 0;
      while (!s_axil_bvalid && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) chk("b_wait", 32'(s_axil_bvalid), 32'd1);
      repeat (stall) @(negedge clk);
      resp = s_axil_bresp;
      s_axil_bready = 1'b1;
      @(negedge clk);
      s_axil_bready = 1'b0;
   endtask

   task automatic do_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awd, input int wd, input int stall, output logic [1:0] resp);
      logic [1:0] r;
      fork
         drive_aw(addr, awd);
         drive_w(data, strb, wd);
         drive_b(stall, r);
      join
      resp = r;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0]  rsp;
      logic [31:0] a;
      aresetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_awready", 32'(s_axil_awready), 32'd0);
      chk("rst_wready", 32'(s_axil_wready), 32'd0);
      chk("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
      chk("rst_bresp", 32'(s_axil_bresp), 32'd0);
      chk("rst_pulse", 32'(reg_wr_pulse), 32'd0);
      aresetn = 1'b1;
      @(negedge clk);
      chk("rel_awready", 32'(s_axil_awready), 32'd1);
      chk("rel_wready", 32'(s_axil_wready), 32'd1);

      // AW and W in the same cycle
      do_txn(32'h1000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, rsp);
      chk("t030_bresp", 32'(rsp), 32'd0);
      chk("t030_reg2", reg_q[2], 32'hDEAD_BEEF);

      // W three cycles ahead of AW
      do_txn(32'h1000_0000, 32'h1122_3344, 4'hF, 3, 0, 0, rsp);
      chk("t031_bresp", 32'(rsp), 32'd0);
      chk("t031_reg0", reg_q[0], 32'h1122_3344);

      // partial strobe over a prefilled register
      do_txn(32'h1000_0014, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, rsp);
      do_txn(32'h1000_0014, 32'h0000_0000, 4'h5, 1, 0, 0, rsp);
      chk("t032_bresp", 32'(rsp), 32'd0);
      chk("t032_reg5", reg_q[5], 32'hFF00_FF00);

      // out-of-range above and below the window
      do_txn(32'h1000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 0, rsp);
      chk("t033_hi_bresp", 32'(rsp), 32'd2);
      do_txn(32'h0FFF_FFFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, rsp);
      chk("t033_lo_bresp", 32'(rsp), 32'd2);
      chk("t033_reg2", reg_q[2], 32'hDEAD_BEEF);

      // response held off for 10 cycles
      do_txn(32'h1000_000C, 32'h5555_AAAA, 4'hF, 0, 0, 10, rsp);
      chk("t034_bresp", 32'(rsp), 32'd0);
      chk("t034_reg3", reg_q[3], 32'h5555_AAAA);

      // reset asserted during the commit cycle
      s_axil_awaddr = 32'h1000_0008; s_axil_awvalid = 1'b1;
      s_axil_wdata = 32'h1234_5678;  s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      @(negedge clk);
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      aresetn = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      @(negedge clk);
      chk("t035_awready", 32'(s_axil_awready), 32'd1);
      chk("t035_wready", 32'(s_axil_wready), 32'd1);
      chk("t035_reg2", reg_q[2], 32'h0000_0000);
      chk("t035_reg0", reg_q[0], 32'h0000_0000);

      // randomized traffic
      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(7, 0))
            6:       a = BASE + 32'h40 + 4 * $urandom_range(63, 0);
            7:       a = BASE - 4 * $urandom_range(4, 1);
            default: a = BASE + 4 * $urandom_range(15, 0) + $urandom_range(3, 0);
         endcase
         do_txn(a, $urandom, 4'($urandom_range(15, 0)), $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(2, 0), rsp);
         chk("rand_bresp", 32'(rsp), in_range(a) ? 32'd0 : 32'd2);
      end

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
